seg_scan_driver: RTL and testbench

Eight-digit multiplexed seven-segment display driver for the timer display path. Consumes up to eight BCD nibbles from the counter stages and drives the shared active-low segment bus and anode enables, one digit at a time, with an anti-ghosting blank interval per slot. A double-buffered digit register loads new values only at frame boundaries, so counter updates never tear a displayed frame. Replaces the fixed single-anode drive at the display end of the timer.

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 114 +++++++++++
 tb/tb_seg_scan_driver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the timer counter stages and the seven-segment scan driver.
// The counter side is the master; the scan driver is the slave.
interface seg_scan_driver_if;
  logic [31:0] digits;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic        update;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  AN;
  logic        frame_tc;

  // update is a level request with no ready: it is latched into a pending flag
  // and served at the next frame boundary, where frame_tc acknowledges the load.
  modport master (
    output digits, dp_in, digit_en, lz_blank, update,
    input  seg, dp, AN, frame_tc
  );

  modport slave (
    input  digits, dp_in, digit_en, lz_blank, update,
    output seg, dp, AN, frame_tc
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with a frame-aligned shadow register,
// per-slot anti-ghosting blank, and leading-zero suppression. Outputs are active-low.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input logic           clk,
    input logic           reset,
    seg_scan_driver_if.slave bus
);

    localparam int          CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [31:0] BLANK_U = 32'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    shadow_dp_q, shadow_dp_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [7:0]    an_q, an_d;
    logic          frame_tc_q, frame_tc_d;

    logic          wrap;
    logic          boundary;
    logic          load;
    logic [7:0]    sup;
    logic          nz_above;
    logic [3:0]    cur_nib;
    logic          lit;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b1000000;
            4'd1:    dec7 = 7'b1111001;
            4'd2:    dec7 = 7'b0100100;
            4'd3:    dec7 = 7'b0110000;
            4'd4:    dec7 = 7'b0011001;
            4'd5:    dec7 = 7'b0010010;
            4'd6:    dec7 = 7'b0000010;
            4'd7:    dec7 = 7'b1111000;
            4'd8:    dec7 = 7'b0000000;
            4'd9:    dec7 = 7'b0010000;
            default: dec7 = 7'b1111111;
        endcase
    endfunction

    assign wrap     = (cnt_q == CNT_MAX);
    assign boundary = wrap && (idx_q == 3'd7);
    assign load     = boundary && (pending_q || bus.update);

    always_comb begin
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        idx_d       = wrap ? idx_q + 3'd1 : idx_q;
        // An update arriving on the boundary cycle itself is consumed there.
        pending_d   = boundary ? 1'b0 : (pending_q || bus.update);
        shadow_d    = load ? bus.digits : shadow_q;
        shadow_dp_d = load ? bus.dp_in : shadow_dp_q;
        frame_tc_d  = load;
    end

    // Walk from the most significant digit down; only an enabled non-zero
    // digit ends the run of suppressed leading zeros.
    always_comb begin
        sup      = '0;
        nz_above = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if ((i != 0) && bus.lz_blank && (shadow_q[4*i +: 4] == 4'd0) && !nz_above)
                sup[i] = 1'b1;
            if (bus.digit_en[i] && (shadow_q[4*i +: 4] != 4'd0))
                nz_above = 1'b1;
        end
    end

    always_comb begin
        cur_nib = shadow_q[{idx_q, 2'b00} +: 4];
        lit     = bus.digit_en[idx_q] && !sup[idx_q] && (32'(cnt_q) >= BLANK_U);
        an_d    = lit ? ~(8'd1 << idx_q) : 8'hFF;
        seg_d   = lit ? dec7(cur_nib) : 7'h7F;
        dp_d    = lit ? ~shadow_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shadow_q    <= 32'd0;
            shadow_dp_q <= 8'd0;
            pending_q   <= 1'b0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 8'hFF;
            frame_tc_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_tc_q  <= frame_tc_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.AN       = an_q;
    assign bus.frame_tc = frame_tc_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, BLANK_CYC=1 (32-cycle frame).
// Slot k of a frame is blank on edge 4k+1 and lit on edges 4k+2..4k+4 after frame_tc.
module tb_seg_scan_driver;
  localparam int RDIV = 4;
  localparam int BLNK = 1;

  logic clk = 1'b0;
  logic reset;
  int   checks_total  = 0;
  int   checks_passed = 0;
  logic [14:0] exp_q[$];

  seg_scan_driver_if bus ();

  seg_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLNK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  dpv;
    logic [7:0]  en;
    logic        lz;
    int          slot;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t[16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    return t[n];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic wait_tc();
    int n;
    n = 0;
    while (bus.frame_tc !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("frame_tc_seen", 32'(bus.frame_tc), 32'd1);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dpv,
                      input logic [7:0] en, input logic lz);
    bus.digits   = d;
    bus.dp_in    = dpv;
    bus.digit_en = en;
    bus.lz_blank = lz;
    bus.update   = 1'b1;
    tick(1);
    bus.update   = 1'b0;
    wait_tc();
  endtask

  initial begin
    int tc_cnt;
    int per;
    logic [14:0] e;

    vecs[0]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 7, 8'hFF, 7'h7F, 1'b1};
    vecs[1]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 3, 8'hFF, 7'h7F, 1'b1};
    vecs[2]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 2, 8'hFB, 7'h30, 1'b1};
    vecs[3]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 1, 8'hFD, 7'h40, 1'b1};
    vecs[4]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 0, 8'hFE, 7'h12, 1'b1};
    vecs[5]  = '{32'h00000000, 8'h00, 8'hFF, 1'b1, 0, 8'hFE, 7'h40, 1'b1};
    vecs[6]  = '{32'h00000000, 8'h00, 8'hFF, 1'b1, 1, 8'hFF, 7'h7F, 1'b1};
    vecs[7]  = '{32'h00000A00, 8'h04, 8'hFF, 1'b0, 2, 8'hFB, 7'h7F, 1'b0};
    vecs[8]  = '{32'h87654321, 8'h00, 8'hF7, 1'b0, 3, 8'hFF, 7'h7F, 1'b1};
    vecs[9]  = '{32'h87654321, 8'h00, 8'hF7, 1'b0, 4, 8'hEF, 7'h12, 1'b1};
    vecs[10] = '{32'h10000005, 8'h00, 8'h7F, 1'b1, 6, 8'hFF, 7'h7F, 1'b1};
    vecs[11] = '{32'h10000005, 8'h00, 8'hFF, 1'b1, 6, 8'hBF, 7'h40, 1'b1};
    vecs[12] = '{32'h87654321, 8'h81, 8'hFF, 1'b0, 7, 8'h7F, 7'h00, 1'b0};
    vecs[13] = '{32'h87654321, 8'h81, 8'hFF, 1'b0, 0, 8'hFE, 7'h79, 1'b0};
    vecs[14] = '{32'h87654321, 8'h81, 8'hFF, 1'b0, 1, 8'hFD, 7'h24, 1'b1};

    // Clock/reset
    reset        = 1'b1;
    bus.digits   = 32'd0;
    bus.dp_in    = 8'd0;
    bus.digit_en = 8'hFF;
    bus.lz_blank = 1'b0;
    bus.update   = 1'b0;
    tick(3);
    chk("rst_an", 32'(bus.AN), 32'hFF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_tc", 32'(bus.frame_tc), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    chk("post_rst_blank_an", 32'(bus.AN), 32'hFF);
    tick(1);
    chk("post_rst_slot0_an", 32'(bus.AN), 32'hFE);
    chk("post_rst_slot0_seg", 32'(bus.seg), 32'h40);

    // Load 87654321 and check two full frames of scan order against the queue
    load(32'h87654321, 8'h00, 8'hFF, 1'b0);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back({8'hFF, 7'h7F});
        for (int p = 1; p < 4; p++) begin
          e = {~(8'd1 << k), seg_of(4'((32'h87654321 >> (4 * k)) & 32'hF))};
          exp_q.push_back(e);
        end
      end
    tc_cnt = 0;
    for (int n = 1; n <= 64; n++) begin
      tick(1);
      if (bus.frame_tc === 1'b1) tc_cnt++;
      e = exp_q.pop_front();
      chk($sformatf("scan_e%0d", n), {17'd0, bus.AN, bus.seg}, {17'd0, e});
    end
    chk("tc_single_pulse", tc_cnt, 0);

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      load(vecs[i].digits, vecs[i].dpv, vecs[i].en, vecs[i].lz);
      tick(4 * vecs[i].slot + 2);
      chk($sformatf("vec%0d_an", i), 32'(bus.AN), 32'(vecs[i].an));
      chk($sformatf("vec%0d_seg", i), 32'(bus.seg), 32'(vecs[i].seg));
      chk($sformatf("vec%0d_dp", i), 32'(bus.dp), 32'(vecs[i].dp));
    end

    // Mid-frame update must not tear the frame
    load(32'h87654321, 8'h00, 8'hFF, 1'b0);
    tick(10);
    bus.digits = 32'h22222222;
    bus.update = 1'b1;
    tick(1);
    bus.update = 1'b0;
    tick(3);
    chk("mid_old_an", 32'(bus.AN), 32'hF7);
    chk("mid_old_seg", 32'(bus.seg), 32'h19);
    tick(17);
    chk("mid_tc_early", 32'(bus.frame_tc), 32'd0);
    tick(1);
    chk("mid_tc_boundary", 32'(bus.frame_tc), 32'd1);
    chk("mid_slot7_an", 32'(bus.AN), 32'h7F);
    chk("mid_slot7_old_seg", 32'(bus.seg), 32'h00);
    tick(2);
    chk("mid_new_an", 32'(bus.AN), 32'hFE);
    chk("mid_new_seg", 32'(bus.seg), 32'h24);

    // update held high: frame_tc period equals frame period
    bus.update = 1'b1;
    wait_tc();
    tick(1);
    per = 1;
    while (bus.frame_tc !== 1'b1 && per < 100) begin
      tick(1);
      per++;
    end
    bus.update = 1'b0;
    chk("tc_period", per, 8 * RDIV);

    // Reset mid-frame during slot 5 with an update pending
    load(32'h87654321, 8'h00, 8'hFF, 1'b0);
    tick(22);
    chk("pre_rst_slot5_an", 32'(bus.AN), 32'hDF);
    bus.update = 1'b1;
    tick(1);
    bus.update = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_an", 32'(bus.AN), 32'hFF);
    chk("async_rst_seg", 32'(bus.seg), 32'h7F);
    chk("async_rst_dp", 32'(bus.dp), 32'd1);
    chk("async_rst_tc", 32'(bus.frame_tc), 32'd0);
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    chk("rerun_blank_an", 32'(bus.AN), 32'hFF);
    tick(1);
    chk("rerun_slot0_an", 32'(bus.AN), 32'hFE);
    chk("rerun_slot0_seg", 32'(bus.seg), 32'h40);
    tc_cnt = 0;
    for (int n = 0; n < 70; n++) begin
      tick(1);
      if (bus.frame_tc === 1'b1) tc_cnt++;
    end
    chk("pending_lost", tc_cnt, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
